// File: rtl/register_file_pkg.sv
// Shared constants for the general-purpose register file.
package register_file_pkg;
   localparam int REG_DATA_W    = 32;
   localparam int REG_ADDR_W    = 5;
   localparam int REG_COUNT     = 2 ** REG_ADDR_W;
   localparam int REG_ZERO_ADDR = 0;
endpackage

// File: rtl/register_file_cell.sv
// register_cell: one storage register with load enable and asynchronous active-low clear.
module register_cell #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);
   logic [DATA_W-1:0] val_q;
   logic [DATA_W-1:0] val_d;

   always_comb begin
      val_d = val_q;
      if (load) val_d = d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) val_q <= '0;
      else        val_q <= val_d;
   end

   assign q = val_q;
endmodule

// File: rtl/register_file.sv
// 32x32 register file: one write port driven by a one-hot decoder vector, two combinational reads.
// Define REGFILE_WRITE_BYPASS_EN to forward the write data to a same-cycle read of the written address.
module register_file
   import register_file_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     wa,
   input  logic [2**ADDR_W-1:0]  wsel,
   input  logic [DATA_W-1:0]     wd,
   input  logic [ADDR_W-1:0]     ra_a,
   input  logic [ADDR_W-1:0]     ra_b,
   output logic [DATA_W-1:0]     rd_a,
   output logic [DATA_W-1:0]     rd_b,
   output logic                  wsel_err
);
   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NREG];
   logic [NREG-1:0]   wsel_exp;
   logic              err_d;
   logic              err_q;

   // R0 has no storage; it always reads as zero.
   assign regs[REG_ZERO_ADDR] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         register_cell #(.DATA_W(DATA_W)) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (wsel[gi]),
            .d     (wd),
            .q     (regs[gi])
         );
      end
   endgenerate

   always_comb begin
      rd_a = regs[ra_a];
      rd_b = regs[ra_b];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && (wa != ADDR_W'(REG_ZERO_ADDR)) && (ra_a == wa)) rd_a = wd;
      if (we && (wa != ADDR_W'(REG_ZERO_ADDR)) && (ra_b == wa)) rd_b = wd;
`endif
   end

   // Sticky flag: the decoder vector disagreed with the exact decode of wa/we.
   always_comb begin
      wsel_exp = '0;
      if (we) wsel_exp[wa] = 1'b1;
      err_d = err_q | (wsel != wsel_exp);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign wsel_err = err_q;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: randomized and directed cycles against an array model.
module tb_register_file;
   import register_file_pkg::*;

   logic                  clk;
   logic                  rst_n;
   logic                  we;
   logic [REG_ADDR_W-1:0] wa;
   logic [REG_COUNT-1:0]  wsel;
   logic [REG_DATA_W-1:0] wd;
   logic [REG_ADDR_W-1:0] ra_a;
   logic [REG_ADDR_W-1:0] ra_b;
   logic [REG_DATA_W-1:0] rd_a;
   logic [REG_DATA_W-1:0] rd_b;
   logic                  wsel_err;

   register_file dut (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wsel(wsel), .wd(wd),
      .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b), .wsel_err(wsel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        err;
      string       nm;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mdl [REG_COUNT];
   logic        mdl_err;
   int          vectors = 0;
   int          miscompares = 0;

   function automatic logic [31:0] mdl_read(input logic [4:0] ra);
      logic [31:0] v;
      v = (ra == 0) ? 32'h0 : mdl[ra];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && wa != 0 && ra == wa) v = wd;
`endif
      return v;
   endfunction

   // Drive one cycle: set inputs after the previous edge, queue the expectation, then advance the model.
   task automatic cyc(input logic rst, input logic we_i, input logic [4:0] wa_i,
                      input logic [31:0] wsel_i, input logic [31:0] wd_i,
                      input logic [4:0] a_i, input logic [4:0] b_i, input string nm);
      exp_t e;
      logic nerr;
      rst_n = rst; we = we_i; wa = wa_i; wsel = wsel_i; wd = wd_i; ra_a = a_i; ra_b = b_i;
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) mdl[i] = 32'h0;
         mdl_err = 1'b0;
      end
      e.a = mdl_read(a_i);
      e.b = mdl_read(b_i);
      e.err = mdl_err;
      e.nm = nm;
      exp_q.push_back(e);
      nerr = mdl_err | (wsel_i != (we_i ? (32'h1 << wa_i) : 32'h0));
      @(posedge clk);
      if (rst_n) begin
         for (int i = 1; i < REG_COUNT; i++) if (wsel_i[i]) mdl[i] = wd_i;
         mdl_err = nerr;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         vectors++;
         if (rd_a !== e.a) begin
            miscompares++;
            $display("FAIL %s rd_a: got %h expected %h", e.nm, rd_a, e.a);
         end
         if (rd_b !== e.b) begin
            miscompares++;
            $display("FAIL %s rd_b: got %h expected %h", e.nm, rd_b, e.b);
         end
         if (wsel_err !== e.err) begin
            miscompares++;
            $display("FAIL %s wsel_err: got %b expected %b", e.nm, wsel_err, e.err);
         end
         $display("chk %s ra_a=%0d rd_a=%h ra_b=%0d rd_b=%h err=%b", e.nm, ra_a, rd_a, ra_b, rd_b, wsel_err);
      end
   end

   initial begin
      logic [4:0]  wa_r;
      logic        we_r;
      logic [31:0] wsel_r;
      rst_n = 1'b0; we = 0; wa = 0; wsel = 0; wd = 0; ra_a = 0; ra_b = 0;
      mdl_err = 1'b0;
      for (int i = 0; i < REG_COUNT; i++) mdl[i] = 32'h0;
      @(posedge clk); #1;
      cyc(0, 0, 0, 0, 0, 5, 6, "reset_init");
      cyc(1, 1, 5, 32'h20, 32'hDEADBEEF, 5, 6, "basic_wr");
      cyc(1, 0, 0, 0, 0, 5, 6, "basic_rd");
      cyc(1, 1, 0, 32'h1, 32'hFFFFFFFF, 0, 5, "r0_wr");
      cyc(1, 0, 0, 0, 0, 0, 5, "r0_rd");
      cyc(1, 1, 7, 32'h80, 32'h11, 7, 0, "r7_init");
      cyc(1, 1, 7, 32'h80, 32'h22, 7, 7, "same_cycle");
      cyc(1, 0, 0, 0, 0, 7, 7, "after_wr");
      for (int i = 1; i < REG_COUNT; i++)
         cyc(1, 1, 5'(i), 32'h1 << i, 32'h01010101 * i, 5'(i), 0, "sweep_wr");
      for (int i = 0; i < REG_COUNT; i++)
         cyc(1, 0, 0, 0, 0, 5'(i), 5'(31 - i), "sweep_rd");
      // Reset with live data, including an attempted write while reset is held.
      cyc(0, 1, 5, 32'h20, 32'hCAFEF00D, 5, 9, "reset_mid");
      cyc(1, 0, 0, 0, 0, 5, 9, "reset_post");
      for (int n = 0; n < 200; n++) begin
         we_r = 1'($urandom_range(0, 1));
         wa_r = 5'($urandom);
         wsel_r = we_r ? (32'h1 << wa_r) : 32'h0;
         cyc(1, we_r, wa_r, wsel_r, $urandom, 5'($urandom),
             ($urandom_range(0, 3) == 0) ? wa_r : 5'($urandom), "rand");
      end
      cyc(1, 1, 3, 32'h18, 32'h33333333, 3, 4, "mismatch_wr");
      for (int n = 0; n < 4; n++) cyc(1, 0, 0, 0, 0, 3, 4, "mismatch_sticky");
      cyc(0, 0, 0, 0, 0, 3, 4, "mismatch_clr");
      for (int n = 0; n < 150; n++) begin
         we_r = 1'($urandom_range(0, 1));
         wa_r = 5'($urandom);
         wsel_r = we_r ? (32'h1 << wa_r) : 32'h0;
         if ($urandom_range(0, 29) == 0) wsel_r = $urandom;
         cyc(($urandom_range(0, 49) != 0), we_r, wa_r, wsel_r, $urandom,
             5'($urandom), 5'($urandom), "rand_err");
      end
      cyc(1, 0, 0, 0, 0, 0, 0, "final");
      @(posedge clk); #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
